// File: rtl/scfifo_s_rd_ctrl.sv
// ---------------------------------------------------------------------------
// scfifo_s_rd_ctrl
//
// Read-side controller for the single-clock FIFO. It reads from a RAM with
// one cycle of read latency and presents the head word in show-ahead mode
// from a two-entry output buffer (head + skid).
//
// Ports:
//   clk          single clock
//   aclr         asynchronous active-high reset (shared with the writer)
//   wr_ptr       writer's registered pointer, MSB is the wrap bit
//   rd_ptr       registered read pointer, MSB is the wrap bit, to the writer
//   ram_raddr    RAM read address (low bits of rd_ptr)
//   ram_rden     RAM read enable; one strobe issues one word
//   ram_rdata    RAM read data, valid the cycle after ram_rden
//   rd_req       consumer pop request
//   q            head-of-FIFO data (show-ahead)
//   q_valid      q holds a valid word
//   empty        inverse of q_valid
//   almost_empty registered, usedw below ALMOST_EMPTY_VALUE
//   usedw        registered count of words in RAM, in flight and buffered
//   underflow    registered one-cycle pulse for rd_req while nothing is valid
// ---------------------------------------------------------------------------
module scfifo_s_rd_ctrl #(
  parameter int WIDTH              = 8,
  parameter int ADDR_WIDTH         = 5,
  parameter int ALMOST_EMPTY_VALUE = 4
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_rden,
  input  logic [WIDTH-1:0]      ram_rdata,
  input  logic                  rd_req,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH+1:0] usedw,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH+1:0] AE_THRESH = (ADDR_WIDTH+2)'(ALMOST_EMPTY_VALUE);
  localparam logic                  AE_RESET  = (ALMOST_EMPTY_VALUE > 0);

  logic [ADDR_WIDTH:0]   rdPtr_q, rdPtr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            outCnt_q, outCnt_d;
  logic [WIDTH-1:0]      head_q, head_d;
  logic [WIDTH-1:0]      skid_q, skid_d;
  logic [ADDR_WIDTH+1:0] usedw_q, usedw_d;
  logic                  almostEmpty_q, almostEmpty_d;
  logic                  underflow_q, underflow_d;

  logic [ADDR_WIDTH:0]   ramWords;
  logic [ADDR_WIDTH:0]   ramWordsNext;
  logic                  qValid;
  logic                  pop;
  logic [2:0]            occupancy;
  logic                  issue;
  logic [1:0]            cntAfterPop;

  // Issue decision. The modular pointer difference gives the number of
  // readable words in RAM, including across the wrap. A read is issued only
  // if the word it returns is guaranteed a free buffer slot once this
  // cycle's pop is accounted for, which is what lets the buffer sustain one
  // pop per cycle without ever overflowing. Issue is gated while aclr is
  // asserted so no read leaks out during reset.
  always_comb begin
    ramWords  = wr_ptr - rdPtr_q;
    qValid    = (outCnt_q != 2'd0);
    pop       = rd_req & qValid;
    occupancy = {1'b0, outCnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    issue     = !aclr && (ramWords != '0) && (occupancy <= 3'd1);
  end

  // Next-state for pointer, output buffer and status. The pop is applied
  // first (skid moves to head when both entries were full), then the
  // returning RAM word lands in the first entry that is still free. usedw
  // and almost_empty are computed from the next-state values so the
  // registered copies describe the FIFO as it stands after the edge.
  always_comb begin
    rdPtr_d      = rdPtr_q + {{ADDR_WIDTH{1'b0}}, issue};
    inflight_d   = issue;
    head_d       = head_q;
    skid_d       = skid_q;
    cntAfterPop  = outCnt_q - {1'b0, pop};

    if (pop && (outCnt_q == 2'd2)) begin
      head_d = skid_q;
    end

    if (inflight_q) begin
      if (cntAfterPop == 2'd0) begin
        head_d = ram_rdata;
      end else begin
        skid_d = ram_rdata;
      end
    end

    outCnt_d      = cntAfterPop + {1'b0, inflight_q};
    ramWordsNext  = wr_ptr - rdPtr_d;
    usedw_d       = {1'b0, ramWordsNext}
                  + {{(ADDR_WIDTH+1){1'b0}}, inflight_d}
                  + {{ADDR_WIDTH{1'b0}}, outCnt_d};
    almostEmpty_d = (usedw_d < AE_THRESH);
    underflow_d   = rd_req & ~qValid;
  end

  // State registers. aclr discards everything in flight and buffered at
  // once; the writer is cleared by the same reset so the pointers agree.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rdPtr_q       <= '0;
      inflight_q    <= 1'b0;
      outCnt_q      <= 2'd0;
      head_q        <= '0;
      skid_q        <= '0;
      usedw_q       <= '0;
      almostEmpty_q <= AE_RESET;
      underflow_q   <= 1'b0;
    end else begin
      rdPtr_q       <= rdPtr_d;
      inflight_q    <= inflight_d;
      outCnt_q      <= outCnt_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
      usedw_q       <= usedw_d;
      almostEmpty_q <= almostEmpty_d;
      underflow_q   <= underflow_d;
    end
  end

  // Buffered plus in-flight words can never exceed the two buffer entries.
  assert property (@(posedge clk) disable iff (aclr)
                   (({1'b0, outCnt_q} + {2'b0, inflight_q}) <= 3'd2));

  assign rd_ptr       = rdPtr_q;
  assign ram_raddr    = rdPtr_q[ADDR_WIDTH-1:0];
  assign ram_rden     = issue;
  assign q            = head_q;
  assign q_valid      = qValid;
  assign empty        = ~qValid;
  assign almost_empty = almostEmpty_q;
  assign usedw        = usedw_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_scfifo_s_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scfifo_s_rd_ctrl
//
// Directed bench for scfifo_s_rd_ctrl. The bench plays the writer and the
// one-cycle-latency RAM, and keeps a scoreboard of written words plus an
// expected word count.
// ---------------------------------------------------------------------------
module tb_scfifo_s_rd_ctrl;

  localparam int WIDTH      = 8;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                  clk;
  logic                  aclr;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic                  ram_rden;
  logic [WIDTH-1:0]      ram_rdata;
  logic                  rd_req;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH+1:0] usedw;
  logic                  underflow;

  scfifo_s_rd_ctrl #(
    .WIDTH(WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ALMOST_EMPTY_VALUE(4)
  ) dut (
    .clk(clk),
    .aclr(aclr),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .ram_raddr(ram_raddr),
    .ram_rden(ram_rden),
    .ram_rdata(ram_rdata),
    .rd_req(rd_req),
    .q(q),
    .q_valid(q_valid),
    .empty(empty),
    .almost_empty(almost_empty),
    .usedw(usedw),
    .underflow(underflow)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with one cycle of read latency
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_rden) ram_rdata <= mem[ram_raddr];
  end

  int               checkCount = 0;
  int               passCount  = 0;
  logic [WIDTH-1:0] sb[$];
  logic [ADDR_WIDTH:0] wrPtr = '0;
  logic [WIDTH-1:0] dataCtr = '0;
  int               expUsed = 0;
  int               popCount = 0;
  int               issueCount = 0;
  logic             lastRden;
  logic [ADDR_WIDTH-1:0] lastRaddr;
  logic             sawPop;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: optionally write one word, drive rd_req, check any pop
  // against the scoreboard, then check the registered count after the edge.
  task automatic applyStimulus(input bit doWrite, input logic rr);
    @(negedge clk);
    if (doWrite) begin
      mem[wrPtr[ADDR_WIDTH-1:0]] = dataCtr;
      sb.push_back(dataCtr);
      dataCtr++;
      wrPtr++;
      expUsed++;
    end
    wr_ptr = wrPtr;
    rd_req = rr;
    sawPop = rr & q_valid;
    if (sawPop) begin
      if (sb.size() == 0) begin
        checkOutput("popUnderrun", 32'd1, 32'd0);
      end else begin
        checkOutput("popData", 32'(q), 32'(sb[0]));
        void'(sb.pop_front());
        expUsed--;
      end
      popCount++;
    end
    #1;
    lastRden  = ram_rden;
    lastRaddr = ram_raddr;
    if (lastRden) issueCount++;
    @(posedge clk);
    #1;
    checkOutput("usedw", 32'(usedw), 32'(expUsed));
    checkOutput("almostEmpty", 32'(almost_empty), 32'(expUsed < 4));
    checkOutput("emptyInv", 32'(empty), 32'(!q_valid));
  endtask

  task automatic doReset();
    @(negedge clk);
    aclr   = 1'b1;
    rd_req = 1'b0;
    wrPtr  = '0;
    wr_ptr = '0;
    sb.delete();
    expUsed    = 0;
    popCount   = 0;
    issueCount = 0;
    @(negedge clk);
    aclr = 1'b0;
  endtask

  int  toggles;
  int  toggleAt1;
  int  toggleAt2;
  logic prevMsb;
  int  written;

  initial begin
    aclr   = 1'b1;
    wr_ptr = '0;
    rd_req = 1'b0;
    #12;

    // Reset values while aclr is held
    checkOutput("rstQValid", 32'(q_valid), 32'd0);
    checkOutput("rstEmpty", 32'(empty), 32'd1);
    checkOutput("rstUsedw", 32'(usedw), 32'd0);
    checkOutput("rstAlmostEmpty", 32'(almost_empty), 32'd1);
    checkOutput("rstRdPtr", 32'(rd_ptr), 32'd0);
    checkOutput("rstRden", 32'(ram_rden), 32'd0);
    checkOutput("rstUnderflow", 32'(underflow), 32'd0);
    checkOutput("rstQ", 32'(q), 32'd0);
    @(negedge clk);
    aclr = 1'b0;

    // Idle with nothing written
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("idleRden", 32'(lastRden), 32'd0);
      checkOutput("idleQValid", 32'(q_valid), 32'd0);
    end

    // Single word latency: issue in T, visible in T+2
    dataCtr = 8'hA5;
    applyStimulus(1'b1, 1'b0);
    checkOutput("latRden", 32'(lastRden), 32'd1);
    checkOutput("latRaddr", 32'(lastRaddr), 32'd0);
    checkOutput("latQValidT1", 32'(q_valid), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("latQValidT2", 32'(q_valid), 32'd1);
    checkOutput("latQ", 32'(q), 32'hA5);
    checkOutput("latUsedw", 32'(usedw), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("latEmptyAfterPop", 32'(empty), 32'd1);
    checkOutput("latUsedwAfterPop", 32'(usedw), 32'd0);

    // Preload ten words then stream them out back to back
    dataCtr = 8'd0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("streamNoGap", 32'(sawPop), 32'd1);
      checkOutput("streamUnderflow", 32'(underflow), 32'd0);
    end
    checkOutput("streamEmpty", 32'(empty), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("underflowPulse", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("underflowClear", 32'(underflow), 32'd0);

    // Backpressure: buffer fills and issue stops two words in
    doReset();
    dataCtr = 8'd0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("bpRdPtr", 32'(rd_ptr), 32'd2);
    checkOutput("bpUsedw", 32'(usedw), 32'd32);
    checkOutput("bpQValid", 32'(q_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("bpPopCount", 32'(popCount), 32'd5);
    checkOutput("bpUsedwAfter", 32'(usedw), 32'd27);

    // Wrap: 100 words with random consumer and a writer that respects full
    doReset();
    dataCtr   = 8'h3C;
    written   = 0;
    toggles   = 0;
    toggleAt1 = 0;
    toggleAt2 = 0;
    prevMsb   = 1'b0;
    for (int cyc = 0; cyc < 3000 && popCount < 100; cyc++) begin
      logic [ADDR_WIDTH:0] diff;
      bit doWr;
      diff = wrPtr - rd_ptr;
      doWr = (written < 100) && (diff < (ADDR_WIDTH+1)'(DEPTH));
      if (doWr) written++;
      applyStimulus(doWr, 1'($urandom_range(0, 1)));
      if (rd_ptr[ADDR_WIDTH] != prevMsb) begin
        toggles++;
        if (toggles == 1) toggleAt1 = issueCount;
        if (toggles == 2) toggleAt2 = issueCount;
        prevMsb = rd_ptr[ADDR_WIDTH];
      end
    end
    checkOutput("wrapDone", 32'(popCount), 32'd100);
    checkOutput("wrapToggle1", 32'(toggleAt1), 32'd32);
    checkOutput("wrapToggle2", 32'(toggleAt2), 32'd64);
    checkOutput("wrapIssues", 32'(issueCount), 32'd100);

    // Reset mid-stream with one word buffered and one in flight
    doReset();
    dataCtr = 8'd0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    aclr = 1'b1;
    #1;
    checkOutput("midRstQValid", 32'(q_valid), 32'd0);
    checkOutput("midRstUsedw", 32'(usedw), 32'd0);
    checkOutput("midRstRdPtr", 32'(rd_ptr), 32'd0);
    checkOutput("midRstRden", 32'(ram_rden), 32'd0);
    checkOutput("midRstAlmostEmpty", 32'(almost_empty), 32'd1);
    rd_req = 1'b0;
    wrPtr  = '0;
    wr_ptr = '0;
    sb.delete();
    expUsed = 0;
    @(negedge clk);
    aclr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("postRstRden", 32'(lastRden), 32'd0);
      checkOutput("postRstQValid", 32'(q_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
